// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sizing defaults and bit-reversal helper
package fft_pkg;

  localparam int FFT_N  = 3;
  localparam int FFT_DW = 16;
  localparam int REV_W  = 16;

  // Reverses the low n bits of v; callers truncate the result to n bits.
  function automatic logic [REV_W-1:0] rev_bit(input logic [REV_W-1:0] v, input int n);
    logic [REV_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_W; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// rtl/fft_reorder_ram.sv - two-bank frame store, sync write and async read
module fft_reorder_ram
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = 2 * FFT_DW
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic         wr_bank,
  input  logic [N-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_bank,
  input  logic [N-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  // Bank select forms the address MSB so both banks share one array.
  logic [W-1:0] mem [2**(N+1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong reorder of bit-reversed FFT frames
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = FFT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [N-1:0]  out_idx,
  output logic          out_last
);

  localparam logic [N-1:0] LAST_IDX = '1;

  logic          wr_bank;
  logic          rd_bank;
  logic [N-1:0]  wr_cnt;
  logic [N-1:0]  rd_cnt;
  logic [1:0]    bank_full;
  logic          accept;
  logic          load;
  logic [N-1:0]  wr_addr;
  logic [2*DW-1:0] rd_data;

  assign in_ready = !bank_full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign load     = bank_full[rd_bank] && (!out_valid || out_ready);
  assign wr_addr  = N'(rev_bit(REV_W'(wr_cnt), N));

  fft_reorder_ram #(
    .N (N),
    .W (2 * DW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // A bank being written is never full and a bank being read always is,
  // so the set and clear below always target different bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bank_full <= 2'b00;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + N'(1);
        if (wr_cnt == LAST_IDX) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
        end
      end

      if (load) begin
        out_re    <= rd_data[2*DW-1:DW];
        out_im    <= rd_data[DW-1:0];
        out_idx   <= rd_cnt;
        out_last  <= (rd_cnt == LAST_IDX);
        out_valid <= 1'b1;
        rd_cnt    <= rd_cnt + N'(1);
        if (rd_cnt == LAST_IDX) begin
          bank_full[rd_bank] <= 1'b0;
          rd_bank            <= ~rd_bank;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - scoreboard bench for the bit-reversal reorder buffer
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int FR = 8;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [N-1:0]  out_idx;
  logic          out_last;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [N-1:0]  idx;
    logic          last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  int   stalls = 0;
  int   run, bad, base, t0;
  bit   done;
  logic [2*DW-1:0] v0;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Natural-order content of frame f at index k.
  function automatic logic [2*DW-1:0] nat(input int f, input int k);
    logic [DW-1:0] re, im;
    if (f == 0) begin
      re = DW'(k);
      im = -DW'(k);
    end else if (f == 99) begin
      case (k % 4)
        0: begin re = 16'h8000; im = 16'h7FFF; end
        1: begin re = 16'h7FFF; im = 16'h8000; end
        2: begin re = 16'h8000; im = 16'h8000; end
        default: begin re = 16'h7FFF; im = 16'h7FFF; end
      endcase
    end else begin
      re = DW'(f * 4096 + k * 33 + 1);
      im = DW'(f * 7 - k * 1000);
    end
    return {re, im};
  endfunction

  task automatic send_frame(input int f, input int pv, input int n);
    logic [2*DW-1:0] v;
    logic [N-1:0]    r;
    exp_t            x;
    int              t;
    for (int k = 0; k < FR; k++) begin
      v      = nat(f, k);
      x.re   = v[2*DW-1:DW];
      x.im   = v[DW-1:0];
      x.idx  = N'(k);
      x.last = (k == FR - 1);
      q.push_back(x);
    end
    for (int j = 0; j < n; j++) begin
      while ($urandom_range(99) >= pv) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      r        = N'(rev_bit(REV_W'(j), N));
      v        = nat(f, int'(r));
      in_valid = 1'b1;
      in_re    = v[2*DW-1:DW];
      in_im    = v[DW-1:0];
      t = 0;
      while (!in_ready && t < TO) begin
        stalls++;
        @(posedge clk); #1;
        t++;
      end
      if (t >= TO) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: frame %0d sample %0d never accepted", f, j);
        break;
      end
      @(posedge clk); #1;
      acc_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: idx %0d arrived, required none", out_idx);
      end else begin
        e = q.pop_front();
        check("out_re",   32'(out_re),   32'(e.re));
        check("out_im",   32'(out_im),   32'(e.im));
        check("out_idx",  32'(out_idx),  32'(e.idx));
        check("out_last", 32'(out_last), 32'(e.last));
        out_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_re",    32'(out_re),    32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);

    // single frame and first-output latency
    out_ready = 1'b1;
    send_frame(0, 100, FR);
    check("lat_before", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_idx",   32'(out_idx),   32'd0);
    drain("drain_single");

    // back-to-back frames must stream with no bubbles
    stalls = 0;
    fork
      begin
        send_frame(1, 100, FR);
        send_frame(2, 100, FR);
        send_frame(3, 100, FR);
      end
      begin
        t0 = 0;
        run = 0;
        while (!out_valid && t0 < TO) begin @(posedge clk); #1; t0++; end
        while (out_valid && run < 30) begin run++; @(posedge clk); #1; end
        check("gapless_run", 32'(run), 32'd24);
      end
    join
    check("b2b_stalls", 32'(stalls), 32'd0);
    drain("drain_b2b");

    // backpressure with both banks filling
    acc_cnt = 0;
    fork
      begin
        send_frame(4, 100, FR);
        send_frame(5, 100, FR);
        send_frame(6, 100, FR);
      end
      begin
        bad = 0;
        v0 = nat(4, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (i >= 10 && (!out_valid || out_idx != 0 || out_re != v0[2*DW-1:DW] || out_im != v0[DW-1:0]))
            bad++;
        end
        check("bp_accepted", 32'(acc_cnt),  32'd16);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold",     32'(bad),      32'd0);
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");

    // random valid/ready stalls
    base = out_cnt;
    done = 1'b0;
    fork
      begin
        for (int f = 10; f < 20; f++) send_frame(f, 50, FR);
        drain("drain_random");
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    check("random_count", 32'(out_cnt - base), 32'd80);

    // reset with one frame half drained and the next partly written
    out_ready = 1'b0;
    send_frame(20, 100, FR);
    fork
      send_frame(21, 100, 5);
      begin
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b0;
      end
    join
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_idx",   32'(out_idx),   32'd0);
    check("midrst_out_last",  32'(out_last),  32'd0);
    out_ready = 1'b1;
    send_frame(22, 100, FR);
    drain("drain_after_rst");

    // sign and width extremes
    send_frame(99, 100, FR);
    drain("drain_extremes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer placed directly downstream of the radix-2 SDF FFT pipeline.
- The SDF stages emit each 2^N-point frame in bit-reversed index order. This block stores each frame and replays it in natural order (X[0], X[1], …, X[2^N-1]).
- Ping-pong double buffer with valid/ready handshakes on both sides, so back-to-back frames stream with no gaps.

Parameters:
- N, 3, log2 of FFT size; frame length is 2^N samples.
- DW, 16, width of each real and imaginary component (two's complement).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- in_valid  input  1  in_re/in_im carry a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_re  input  DW  real part, bit-reversed order.
- in_im  input  DW  imaginary part, bit-reversed order.
- out_valid  output  1  out_re/out_im/out_idx are valid.
- out_ready  input  1  downstream accepts the output sample.
- out_re  output  DW  real part, natural order.
- out_im  output  DW  imaginary part, natural order.
- out_idx  output  N  natural frequency index of the current output.
- out_last  output  1  high with index 2^N-1.

Behaviour:
- Reset (rst_n=0 at an edge) clears all of the following:
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00.
  - out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0.
  - Buffer RAM contents are not cleared.
  - Any partially written frame or partially drained frame is discarded.
- Input accept rule:
  - A sample is accepted when in_valid && in_ready.
  - in_ready = !bank_full[wr_bank]. It is combinational from registered state only, with no path from in_valid.
- Write path:
  - The accepted sample is written to bank wr_bank at address rev_bit(wr_cnt), where rev_bit is the N-bit reversal.
  - wr_cnt increments by 1 and wraps from 2^N-1 to 0.
  - On acceptance of the sample with wr_cnt=2^N-1: set bank_full[wr_bank]=1 and toggle wr_bank.
- Read side, output register stage:
  - The output registers load when bank_full[rd_bank] && (!out_valid || out_ready).
  - Loaded values: out_re/out_im = bank[rd_bank][rd_cnt], out_idx = rd_cnt, out_last = (rd_cnt == 2^N-1), out_valid = 1.
  - rd_cnt then increments and wraps.
  - When rd_cnt=2^N-1 is loaded: clear bank_full[rd_bank] and toggle rd_bank.
- Read side, idle:
  - If out_ready && out_valid and no new load occurs, out_valid goes to 0.
  - While out_valid=1 && out_ready=0, all outputs hold stable.
- Latency: the last sample of a frame is accepted at edge k. out_valid=1 with out_idx=0 after edge k+1, provided the output register is free.
- Throughput: one sample per cycle in each direction in steady state, with no bubbles between frames.
- Simultaneous events:
  - Write completing bank A in the same cycle that the read empties bank B: both flag updates apply. The set and the clear target different banks, so they never conflict.
  - Read of the first element is not allowed in the same cycle as the write of the last element. The full flag is registered, which gives the 1-cycle latency above.
- Both banks full: in_ready=0 until the read side releases a bank. The released bank accepts input from the cycle after its last element is loaded.
- Reads and writes never target the same bank, so there is no read/write hazard.
- Arithmetic: data passes through unmodified. There is no scaling and no rounding.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N and FFT_DW defaults.
  - A function rev_bit(N-bit), also used by the index generator and the testbench.
- One natural sub-module, fft_reorder_ram:
  - Two banks of 2^N x 2*DW.
  - One synchronous-write port and one combinational-read port.
  - Bank-select inputs for each port.
- The top level holds the counters, full flags and output register. The top is about 150–250 lines.

Test Plan:
- Single frame, N=3: feed in_re = 0,4,2,6,1,5,3,7 and in_im = -in_re, with out_ready=1. Required output: out_re = 0..7, out_im = 0,-1..-7, out_idx = 0..7, out_last only at idx 7, first out_valid one cycle after the 8th input.
- Back-to-back frames: stream 3 frames continuously with out_ready=1. Required: in_ready stays 1 throughout, the output is gapless 24 samples each in natural order, and frame boundaries are marked by out_last.
- Backpressure: out_ready=0 for 20 cycles while 3 frames are offered. Required: in_ready drops after 16 accepted samples, out_idx=0 holds stable, and all data is correct after out_ready=1.
- Random stalls: random in_valid/out_ready at 50% over 10 frames. Required: the scoreboard (rev_bit model) matches every sample, and no sample is lost or duplicated.
- Reset mid-operation: assert rst_n=0 for 1 cycle after 5 inputs of frame 2 while frame 1 is half drained. Required: the next cycle gives out_valid=0 and in_ready=1, and a new frame then reorders correctly from idx 0.
- Sign and width extremes: DW=16 frame containing 0x8000/0x7FFF. Required: values pass through bit-exact.
